// File: rtl/mem_pkg.sv
// Shared definitions for the memory interface stage: state encoding and default geometry.
package mem_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 9;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int RAM_DEPTH          = 2 ** DEFAULT_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic int ramDepth(input int addrWidth);
        return 2 ** addrWidth;
    endfunction

endpackage

// File: rtl/mem_interface_ram_array.sv
// Single-port synchronous RAM. Contents are never reset; only the output register is.
module ram_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    localparam int DEPTH = ramDepth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= din_i;
        end
    end

    // The output register only loads on a read, so it holds across writes and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (re_i) begin
            dout_q <= mem[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/mem_interface.sv
// Memory-side stage: accepts single-cycle read/write strobes, inserts LATENCY wait
// states, then performs the access and pulses mem_done for one cycle.
module mem_interface
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ram_read,
    input  logic                  ram_write,
    input  logic [31:0]           MAR_q,
    input  logic [DATA_WIDTH-1:0] MDR_q,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_done,
    output logic                  mem_busy,
    output logic                  req_err
);

    localparam logic [3:0] LATENCY_COUNT = 4'(LATENCY);

    mem_state_t            state_q, state_d;
    logic [3:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  opWrite_q, opWrite_d;
    logic                  inRange_q, inRange_d;
    logic                  err_q, err_d;

    logic                  ramWe;
    logic                  ramRe;
    logic                  marInRange;

    assign marInRange = (MAR_q[31:ADDR_WIDTH] == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            opWrite_q <= 1'b0;
            inRange_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            opWrite_q <= opWrite_d;
            inRange_q <= inRange_d;
            err_q     <= err_d;
        end
    end

    // Strobes are only looked at in IDLE; anything arriving while busy is dropped silently.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        data_d    = data_q;
        opWrite_d = opWrite_q;
        inRange_d = inRange_q;
        err_d     = err_q;
        ramWe     = 1'b0;
        ramRe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ram_read ^ ram_write) begin
                    addr_d    = MAR_q[ADDR_WIDTH-1:0];
                    data_d    = MDR_q;
                    opWrite_d = ram_write;
                    inRange_d = marInRange;
                    count_d   = LATENCY_COUNT;
                    state_d   = WAIT;
                    if (!marInRange) begin
                        err_d = 1'b1;
                    end
                end else if (ram_read && ram_write) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    ramWe   = inRange_q & opWrite_q;
                    ramRe   = inRange_q & ~opWrite_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk   (Clock),
        .rst_n (Reset),
        .we_i  (ramWe),
        .re_i  (ramRe),
        .addr_i(addr_q),
        .din_i (data_q),
        .dout_o(Mdatain)
    );

    assign mem_done = (state_q == DONE);
    assign mem_busy = (state_q != IDLE);
    assign req_err  = err_q;

endmodule
